// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: mux select codes, frame
// FSM states and parity type constants, used by the frame controller and the TX mux.
package uart_tx_pkg;

  localparam int MAX_DATA_WIDTH = 9;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Zero-extension to MAX_DATA_WIDTH leaves the XOR-reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic par_typ);
    calc_parity = (par_typ == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Producer-facing request bundle and serial-side outputs of the UART TX frame controller.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; flags the final data bit of a frame.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ser_bit,
  output logic                  o_next_bit,
  output logic                  o_ser_done
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  // Load on accept, shift LSB-first while the FSM is in DATA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= {DATA_WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_shift) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= r_cnt + CNT_W'(1);
    end else begin
      r_shift <= r_shift;
      r_cnt   <= r_cnt;
    end
  end

  assign o_ser_bit  = r_shift[0];
  assign o_next_bit = r_shift[1];
  assign o_ser_done = i_shift && (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
// All outputs are registered alongside the state so nothing is combinational from inputs.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  uart_tx_frame_ctrl_if.slave bus
);
  state_t     r_state;
  logic [1:0] r_mux_sel;
  logic       r_ser_data;
  logic       r_par_bit;
  logic       r_busy;
  logic       r_par_en;

  logic w_accept;
  logic w_shift_en;
  logic w_ser_bit;
  logic w_next_bit;
  logic w_ser_done;

  assign w_accept   = (r_state == IDLE) && bus.DATA_VALID;
  assign w_shift_en = (r_state == DATA);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_accept),
    .i_shift    (w_shift_en),
    .i_data     (bus.P_DATA),
    .o_ser_bit  (w_ser_bit),
    .o_next_bit (w_next_bit),
    .o_ser_done (w_ser_done)
  );

  // Frame FSM; ser_data is loaded with the bit the shift register will present next cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_mux_sel  <= SEL_STOP;
      r_ser_data <= 1'b0;
      r_par_bit  <= 1'b0;
      r_busy     <= 1'b0;
      r_par_en   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ser_data <= 1'b0;
          if (bus.DATA_VALID) begin
            r_state   <= START;
            r_mux_sel <= SEL_START;
            r_busy    <= 1'b1;
            r_par_en  <= bus.PAR_EN;
            r_par_bit <= calc_parity(MAX_DATA_WIDTH'(bus.P_DATA), bus.PAR_TYP);
          end else begin
            r_state   <= IDLE;
            r_mux_sel <= SEL_STOP;
            r_busy    <= 1'b0;
          end
        end
        START: begin
          r_state    <= DATA;
          r_mux_sel  <= SEL_DATA;
          r_ser_data <= w_ser_bit;
          r_busy     <= 1'b1;
        end
        DATA: begin
          r_busy <= 1'b1;
          if (w_ser_done) begin
            r_ser_data <= 1'b0;
            if (r_par_en) begin
              r_state   <= PARITY;
              r_mux_sel <= SEL_PAR;
            end else begin
              r_state   <= STOP;
              r_mux_sel <= SEL_STOP;
            end
          end else begin
            r_state    <= DATA;
            r_mux_sel  <= SEL_DATA;
            r_ser_data <= w_next_bit;
          end
        end
        PARITY: begin
          r_state    <= STOP;
          r_mux_sel  <= SEL_STOP;
          r_ser_data <= 1'b0;
          r_busy     <= 1'b1;
        end
        STOP: begin
          r_state    <= IDLE;
          r_mux_sel  <= SEL_STOP;
          r_ser_data <= 1'b0;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_mux_sel  <= SEL_STOP;
          r_ser_data <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel  = r_mux_sel;
  assign bus.ser_data = r_ser_data;
  assign bus.par_bit  = r_par_bit;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: per-cycle expectations queued at drive time.
module tb_uart_tx_frame_ctrl;

  logic CLK;
  logic RST;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) bus();

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] mux;
    logic       ser;
    logic       ser_chk;
    logic       busy;
    logic       par;
    string      tag;
  } exp_t;

  typedef struct {
    logic [7:0] p_data;
    logic       par_en;
    logic       par_typ;
    logic       exp_par;
    string      tag;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic last_par = 1'b0;

  task automatic push_rec(input logic [1:0] mux, input logic ser, input logic ser_chk,
                          input logic busy, input logic par, input string tag);
    exp_t e;
    e.mux = mux; e.ser = ser; e.ser_chk = ser_chk; e.busy = busy; e.par = par; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic par,
                            input string tag);
    push_rec(2'b00, 1'b0, 1'b0, 1'b1, par, {tag, "_start"});
    for (int i = 0; i < 8; i++)
      push_rec(2'b10, d[i], 1'b1, 1'b1, par, $sformatf("%s_d%0d", tag, i));
    if (pe)
      push_rec(2'b11, 1'b0, 1'b0, 1'b1, par, {tag, "_par"});
    push_rec(2'b01, 1'b0, 1'b0, 1'b1, par, {tag, "_stop"});
    last_par = par;
  endtask

  task automatic push_idle();
    push_rec(2'b01, 1'b0, 1'b0, 1'b0, last_par, "idle");
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge CLK);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.mux_sel !== e.mux || bus.busy !== e.busy || bus.par_bit !== e.par ||
          (e.ser_chk && bus.ser_data !== e.ser)) begin
        errors++;
        $display("FAIL %s: got mux=%b ser=%b busy=%b par=%b, required mux=%b ser=%b busy=%b par=%b",
                 e.tag, bus.mux_sel, bus.ser_data, bus.busy, bus.par_bit,
                 e.mux, e.ser, e.busy, e.par);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (bus.mux_sel !== 2'b01 || bus.ser_data !== 1'b0 || bus.par_bit !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got mux=%b ser=%b par=%b busy=%b, required mux=01 ser=0 par=0 busy=0",
               tag, bus.mux_sel, bus.ser_data, bus.par_bit, bus.busy);
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.DATA_VALID = 1'b0;
    repeat (n) begin
      push_idle();
      cycle();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic par, input string tag);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.DATA_VALID = 1'b1;
    push_frame(d, pe, par, tag);
    cycle();
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = 8'($urandom);
    bus.PAR_EN     = ~pe;
    bus.PAR_TYP    = ~pt;
    repeat (pe ? 10 : 9) cycle();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, "a5_even"};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, "a5_odd"};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, "00_nopar"};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, "00_nopar_odd"};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b1, "01_even"};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, "ff_odd"};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b0, "80_odd_nopar"};
    vecs[7] = '{8'h6B, 1'b1, 1'b0, 1'b1, "6b_even"};

    RST            = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    repeat (2) @(negedge CLK);
    check_reset_vals("reset_hold");
    RST = 1'b1;
    idle_cycles(5);

    foreach (vecs[k]) begin
      send_frame(vecs[k].p_data, vecs[k].par_en, vecs[k].par_typ, vecs[k].exp_par, vecs[k].tag);
      idle_cycles(2);
    end

    // Back-to-back with DATA_VALID held: payload changes mid-frame must not leak in.
    bus.P_DATA     = 8'h3C;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    bus.DATA_VALID = 1'b1;
    push_frame(8'h3C, 1'b1, 1'b0, "b2b_a");
    push_idle();
    push_frame(8'hFF, 1'b1, 1'b0, "b2b_b");
    repeat (4) cycle();
    bus.P_DATA = 8'hFF;
    repeat (7) cycle();
    cycle();
    cycle();
    bus.DATA_VALID = 1'b0;
    repeat (10) cycle();
    idle_cycles(2);

    // Abort during data bit 4; pre-reset par_bit=1 and ser_data=1 so the reset is visible.
    bus.P_DATA     = 8'h5A;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b1;
    bus.DATA_VALID = 1'b1;
    push_frame(8'h5A, 1'b0, 1'b1, "abort");
    cycle();
    bus.DATA_VALID = 1'b0;
    repeat (4) cycle();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check_reset_vals("reset_midframe");
    sb.delete();
    last_par = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_vals("reset_midframe_hold");
    RST = 1'b1;
    idle_cycles(2);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, "post_reset");
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
